// File: rtl/press_classifier.sv
// press_classifier
//
// Times press/release pulses from upstream edge detectors and classifies each
// gesture as a single click, a double click or a long press. Each
// classification is reported as a one-cycle registered pulse.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   press         one-cycle pulse on a rising edge of the debounced button
//   release_pulse one-cycle pulse on a falling edge of the debounced button
//   single_evt    one-cycle pulse: single click classified
//   double_evt    one-cycle pulse: double click classified
//   long_evt      one-cycle pulse: long press classified
//   busy          high whenever a gesture is in progress (state != IDLE)
module press_classifier #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned LONG_CYCLES = 12000000,
  parameter int unsigned GAP_CYCLES  = 6000000
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic release_pulse,
  output logic single_evt,
  output logic double_evt,
  output logic long_evt,
  output logic busy
);

  localparam logic [CNT_W-1:0] LongCnt = LONG_CYCLES[CNT_W-1:0];
  localparam logic [CNT_W-1:0] GapCnt  = GAP_CYCLES[CNT_W-1:0];

  typedef enum logic [2:0] {
    StIdle,
    StHeld1,
    StGap,
    StHeld2,
    StLongWait
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;

  // Simultaneous press and release is treated as a glitch and ignored.
  logic press_v;
  logic release_v;
  assign press_v   = press & ~release_pulse;
  assign release_v = release_pulse & ~press;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      single_evt <= 1'b0;
      double_evt <= 1'b0;
      long_evt   <= 1'b0;
    end else begin
      single_evt <= 1'b0;
      double_evt <= 1'b0;
      long_evt   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (press_v) begin
            state <= StHeld1;
            cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        StHeld1: begin
          // Release takes priority over the long timeout on the same edge.
          if (release_v) begin
            state <= StGap;
            cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (cnt == LongCnt) begin
            state    <= StLongWait;
            long_evt <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StGap: begin
          // Press takes priority over the gap timeout on the same edge.
          if (press_v) begin
            state <= StHeld2;
          end else if (cnt == GapCnt) begin
            state      <= StIdle;
            single_evt <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StHeld2: begin
          if (release_v) begin
            state      <= StIdle;
            double_evt <= 1'b1;
          end
        end
        StLongWait: begin
          if (release_v) begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign busy = (state != StIdle);

endmodule

// File: tb/tb_press_classifier.sv
module tb_press_classifier;

  logic clk;
  logic rst;
  logic press;
  logic release_pulse;
  logic single_evt;
  logic double_evt;
  logic long_evt;
  logic busy;

  int errors = 0;
  int checks = 0;

  // Expected output vectors: {single_evt, double_evt, long_evt, busy}
  localparam logic [3:0] EIdle = 4'b0000;
  localparam logic [3:0] EBusy = 4'b0001;
  localparam logic [3:0] ESgl  = 4'b1000;
  localparam logic [3:0] EDbl  = 4'b0100;
  localparam logic [3:0] ELong = 4'b0011;

  press_classifier #(
    .CNT_W      (4),
    .LONG_CYCLES(8),
    .GAP_CYCLES (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .press        (press),
    .release_pulse(release_pulse),
    .single_evt   (single_evt),
    .double_evt   (double_evt),
    .long_evt     (long_evt),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for one clock edge, then sample outputs 1 time unit later.
  task automatic cyc(input logic p, input logic r, input logic [3:0] exp, input string tag);
    logic [3:0] obs;
    press         = p;
    release_pulse = r;
    @(posedge clk);
    #1;
    press         = 1'b0;
    release_pulse = 1'b0;
    obs = {single_evt, double_evt, long_evt, busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (single,double,long,busy)", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n, input logic [3:0] exp, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, exp, tag);
  endtask

  initial begin
    rst           = 1'b1;
    press         = 1'b0;
    release_pulse = 1'b0;
    cyc(1'b0, 1'b0, EIdle, "reset0");
    cyc(1'b0, 1'b0, EIdle, "reset1");
    rst = 1'b0;
    idle(2, EIdle, "post_reset");

    // Reset mid-gesture discards it.
    cyc(1'b1, 1'b0, EBusy, "rstmid_press");
    idle(2, EBusy, "rstmid_held");
    rst = 1'b1;
    cyc(1'b0, 1'b0, EIdle, "rstmid_rst");
    rst = 1'b0;
    idle(20, EIdle, "rstmid_after");

    // Single click, release at t0+3; glitch pulse inside GAP is ignored.
    cyc(1'b1, 1'b0, EBusy, "sgl_press");
    idle(2, EBusy, "sgl_held");
    cyc(1'b0, 1'b1, EBusy, "sgl_rel");
    idle(1, EBusy, "sgl_gap");
    cyc(1'b1, 1'b1, EBusy, "sgl_gap_glitch");
    idle(2, EBusy, "sgl_gap2");
    cyc(1'b0, 1'b0, ESgl, "sgl_evt");
    idle(2, EIdle, "sgl_after");

    // Single click with release exactly at t0+LONG_CYCLES.
    cyc(1'b1, 1'b0, EBusy, "sgl8_press");
    idle(7, EBusy, "sgl8_held");
    cyc(1'b0, 1'b1, EBusy, "sgl8_rel_at_long");
    idle(4, EBusy, "sgl8_gap");
    cyc(1'b0, 1'b0, ESgl, "sgl8_evt");
    idle(2, EIdle, "sgl8_after");

    // Double click, second press at t0+6.
    cyc(1'b1, 1'b0, EBusy, "dbl_press1");
    idle(1, EBusy, "dbl_held1");
    cyc(1'b0, 1'b1, EBusy, "dbl_rel1");
    idle(3, EBusy, "dbl_gap");
    cyc(1'b1, 1'b0, EBusy, "dbl_press2");
    idle(2, EBusy, "dbl_held2");
    cyc(1'b0, 1'b1, EDbl, "dbl_evt");
    idle(2, EIdle, "dbl_after");

    // Double click, second press exactly at gap timeout.
    cyc(1'b1, 1'b0, EBusy, "dbl5_press1");
    idle(1, EBusy, "dbl5_held1");
    cyc(1'b0, 1'b1, EBusy, "dbl5_rel1");
    idle(4, EBusy, "dbl5_gap");
    cyc(1'b1, 1'b0, EBusy, "dbl5_press2_at_gap");
    idle(1, EBusy, "dbl5_held2");
    cyc(1'b0, 1'b1, EDbl, "dbl5_evt");
    idle(2, EIdle, "dbl5_after");

    // Second press one cycle too late: single, then a new gesture.
    cyc(1'b1, 1'b0, EBusy, "late_press1");
    idle(1, EBusy, "late_held1");
    cyc(1'b0, 1'b1, EBusy, "late_rel1");
    idle(4, EBusy, "late_gap");
    cyc(1'b0, 1'b0, ESgl, "late_sgl");
    cyc(1'b1, 1'b0, EBusy, "late_press2");
    cyc(1'b0, 1'b1, EBusy, "late_rel2");
    idle(4, EBusy, "late_gap2");
    cyc(1'b0, 1'b0, ESgl, "late_sgl2");
    idle(2, EIdle, "late_after");

    // Long press, release at t0+15.
    cyc(1'b1, 1'b0, EBusy, "long_press");
    idle(7, EBusy, "long_held");
    cyc(1'b0, 1'b0, ELong, "long_evt");
    idle(6, EBusy, "long_wait");
    cyc(1'b0, 1'b1, EIdle, "long_rel");
    idle(2, EIdle, "long_after");

    // Stray inputs in IDLE.
    cyc(1'b0, 1'b1, EIdle, "stray_rel_idle");
    cyc(1'b1, 1'b1, EIdle, "glitch_idle");
    idle(2, EIdle, "stray_after");

    // Glitch and extra press in HELD1 do not disturb the long timer.
    cyc(1'b1, 1'b0, EBusy, "gl_press");
    idle(1, EBusy, "gl_held");
    cyc(1'b1, 1'b1, EBusy, "gl_glitch_held1");
    cyc(1'b1, 1'b0, EBusy, "gl_extra_press");
    idle(4, EBusy, "gl_held2");
    cyc(1'b0, 1'b0, ELong, "gl_long_evt");
    cyc(1'b0, 1'b1, EIdle, "gl_rel");

    // Back-to-back: press right after single_evt, then a double click.
    cyc(1'b1, 1'b0, EBusy, "b2b_press1");
    cyc(1'b0, 1'b1, EBusy, "b2b_rel1");
    idle(4, EBusy, "b2b_gap");
    cyc(1'b0, 1'b0, ESgl, "b2b_sgl");
    cyc(1'b1, 1'b0, EBusy, "b2b_press2");
    cyc(1'b0, 1'b1, EBusy, "b2b_rel2");
    idle(1, EBusy, "b2b_gap2");
    cyc(1'b1, 1'b0, EBusy, "b2b_press3");
    cyc(1'b0, 1'b1, EDbl, "b2b_dbl");
    idle(2, EIdle, "b2b_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
